// File: rtl/xm_pkg.sv
// Shared constants, opcode encoding and state encoding for the execute-to-memory stage.
package xm_pkg;

    localparam int unsigned REG_SIZE     = 8;
    localparam int unsigned ADDR_SIZE    = 8;
    localparam int unsigned REG_PTR_SIZE = 4;
    localparam int unsigned OPC_SIZE     = 4;

    localparam logic [OPC_SIZE-1:0] OPC_ADD       = 4'd0;
    localparam logic [OPC_SIZE-1:0] OPC_SUB       = 4'd1;
    localparam logic [OPC_SIZE-1:0] OPC_MUL       = 4'd2;
    localparam logic [OPC_SIZE-1:0] OPC_DIV       = 4'd3;
    localparam logic [OPC_SIZE-1:0] OPC_CMPGE     = 4'd4;
    localparam logic [OPC_SIZE-1:0] OPC_RSHIFT    = 4'd5;
    localparam logic [OPC_SIZE-1:0] OPC_LSHIFT    = 4'd6;
    localparam logic [OPC_SIZE-1:0] OPC_AND       = 4'd7;
    localparam logic [OPC_SIZE-1:0] OPC_OR        = 4'd8;
    localparam logic [OPC_SIZE-1:0] OPC_XOR       = 4'd9;
    localparam logic [OPC_SIZE-1:0] OPC_SET_CONST = 4'd10;
    localparam logic [OPC_SIZE-1:0] OPC_LD        = 4'd11;
    localparam logic [OPC_SIZE-1:0] OPC_ST        = 4'd12;
    localparam logic [OPC_SIZE-1:0] OPC_NOP       = 4'd13;
    localparam logic [OPC_SIZE-1:0] OPC_BRANCH    = 4'd14;
    localparam logic [OPC_SIZE-1:0] OPC_JUMP      = 4'd15;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MEM  = 1'b1
    } xm_state_e;

    // True for every opcode that produces a register-file write (also used by hazard logic).
    function automatic logic writes_reg(input logic [OPC_SIZE-1:0] opc);
        return opc inside {OPC_ADD, OPC_SUB, OPC_MUL, OPC_DIV, OPC_CMPGE, OPC_RSHIFT,
                           OPC_LSHIFT, OPC_AND, OPC_OR, OPC_XOR, OPC_SET_CONST, OPC_LD};
    endfunction

endpackage

// File: rtl/xm_wb_reg.sv
// Register-file write port register. Selects between a retiring load and an ALU result.
// When both arrive on the same edge the load goes first and the ALU result is parked
// for one cycle; later ALU results keep flowing through the park slot until a bubble.
module xm_wb_reg
    import xm_pkg::*;
#(
    parameter int unsigned REG_SIZE     = xm_pkg::REG_SIZE,
    parameter int unsigned REG_PTR_SIZE = xm_pkg::REG_PTR_SIZE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ld_wr,
    input  logic [REG_PTR_SIZE-1:0] ld_ptr,
    input  logic [REG_SIZE-1:0]     ld_data,
    input  logic                    alu_wr,
    input  logic [REG_PTR_SIZE-1:0] alu_ptr,
    input  logic [REG_SIZE-1:0]     alu_data,
    output logic                    W_we,
    output logic [REG_PTR_SIZE-1:0] W_ptr,
    output logic [REG_SIZE-1:0]     W_data
);

    logic                    we_q, we_d;
    logic [REG_PTR_SIZE-1:0] ptr_q, ptr_d;
    logic [REG_SIZE-1:0]     data_q, data_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [REG_PTR_SIZE-1:0] pend_ptr_q, pend_ptr_d;
    logic [REG_SIZE-1:0]     pend_data_q, pend_data_d;

    // Next-state selection: load first, then parked ALU result, then fresh ALU result.
    always_comb begin
        we_d        = 1'b0;
        ptr_d       = ptr_q;
        data_d      = data_q;
        pend_vld_d  = 1'b0;
        pend_ptr_d  = alu_wr ? alu_ptr : pend_ptr_q;
        pend_data_d = alu_wr ? alu_data : pend_data_q;
        if (ld_wr) begin
            we_d       = 1'b1;
            ptr_d      = ld_ptr;
            data_d     = ld_data;
            pend_vld_d = alu_wr;
        end else if (pend_vld_q) begin
            we_d       = 1'b1;
            ptr_d      = pend_ptr_q;
            data_d     = pend_data_q;
            pend_vld_d = alu_wr;
        end else if (alu_wr) begin
            we_d   = 1'b1;
            ptr_d  = alu_ptr;
            data_d = alu_data;
        end
    end

    // Output and park-slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            ptr_q       <= '0;
            data_q      <= '0;
            pend_vld_q  <= 1'b0;
            pend_ptr_q  <= '0;
            pend_data_q <= '0;
        end else begin
            we_q        <= we_d;
            ptr_q       <= ptr_d;
            data_q      <= data_d;
            pend_vld_q  <= pend_vld_d;
            pend_ptr_q  <= pend_ptr_d;
            pend_data_q <= pend_data_d;
        end
    end

    assign W_we   = we_q;
    assign W_ptr  = ptr_q;
    assign W_data = data_q;

endmodule

// File: rtl/xm_stage.sv
// Execute-to-memory/writeback stage: ALU writeback plus a req/ack memory handshake.
module xm_stage
    import xm_pkg::*;
#(
    parameter int unsigned REG_SIZE     = xm_pkg::REG_SIZE,
    parameter int unsigned ADDR_SIZE    = xm_pkg::ADDR_SIZE,
    parameter int unsigned REG_PTR_SIZE = xm_pkg::REG_PTR_SIZE,
    parameter int unsigned OPC_SIZE     = xm_pkg::OPC_SIZE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    X_valid,
    input  logic [OPC_SIZE-1:0]     X_opc,
    input  logic [REG_SIZE-1:0]     X_result_ALU,
    input  logic [REG_SIZE-1:0]     X_st_data,
    input  logic [REG_PTR_SIZE-1:0] X_dst_ptr,
    input  logic                    X_flush,
    output logic                    M_stall,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_SIZE-1:0]    mem_addr,
    output logic [REG_SIZE-1:0]     mem_wdata,
    input  logic                    mem_ack,
    input  logic [REG_SIZE-1:0]     mem_rdata,
    output logic                    W_we,
    output logic [REG_PTR_SIZE-1:0] W_ptr,
    output logic [REG_SIZE-1:0]     W_data
);

    xm_state_e               state_q, state_d;
    logic                    mem_we_q;
    logic [ADDR_SIZE-1:0]    addr_q;
    logic [REG_SIZE-1:0]     wdata_q;
    logic [REG_PTR_SIZE-1:0] ld_ptr_q;

    logic is_ld, is_st, is_mem, in_mem, accept, ld_retire, alu_wr;

    assign is_ld     = (X_opc == OPC_LD);
    assign is_st     = (X_opc == OPC_ST);
    assign is_mem    = is_ld | is_st;
    assign in_mem    = (state_q == MEM);
    assign M_stall   = in_mem & ~mem_ack;
    assign accept    = X_valid & ~X_flush & ~M_stall;
    assign ld_retire = in_mem & mem_ack & ~mem_we_q;
    assign alu_wr    = accept & ~is_mem & writes_reg(X_opc);

    // Next state: enter MEM on an accepted LD/ST; leave only on ack unless another access follows.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept && is_mem) state_d = MEM;
            MEM:  if (mem_ack) state_d = (accept && is_mem) ? MEM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Access registers; only loaded on acceptance, so they stay stable while the access waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ld_ptr_q <= '0;
        end else if (accept && is_mem) begin
            mem_we_q <= is_st;
            addr_q   <= X_result_ALU[ADDR_SIZE-1:0];
            wdata_q  <= is_st ? X_st_data : '0;
            if (is_ld) begin
                ld_ptr_q <= X_dst_ptr;
            end
        end
    end

    assign mem_req   = in_mem;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    xm_wb_reg #(
        .REG_SIZE     (REG_SIZE),
        .REG_PTR_SIZE (REG_PTR_SIZE)
    ) u_wb_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_wr    (ld_retire),
        .ld_ptr   (ld_ptr_q),
        .ld_data  (mem_rdata),
        .alu_wr   (alu_wr),
        .alu_ptr  (X_dst_ptr),
        .alu_data (X_result_ALU),
        .W_we     (W_we),
        .W_ptr    (W_ptr),
        .W_data   (W_data)
    );

endmodule

// File: tb/tb_xm_stage.sv
// Scoreboard bench for xm_stage: directed stimulus, memory responder and writeback monitor.
module tb_xm_stage;
    import xm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       X_valid = 1'b0;
    logic [3:0] X_opc = 4'd0;
    logic [7:0] X_result_ALU = 8'd0;
    logic [7:0] X_st_data = 8'd0;
    logic [3:0] X_dst_ptr = 4'd0;
    logic       X_flush = 1'b0;
    logic       M_stall, mem_req, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic       mem_ack;
    logic       resp_ack = 1'b0;
    logic       idle_ack = 1'b0;
    logic [7:0] mem_rdata = 8'd0;
    logic       W_we;
    logic [3:0] W_ptr;
    logic [7:0] W_data;

    assign mem_ack = resp_ack | idle_ack;

    typedef struct {
        logic [3:0] ptr;
        logic [7:0] data;
    } wb_t;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         delay;
        logic [7:0] rdata;
    } mem_t;

    wb_t  wq[$];
    mem_t mq[$];
    int   checks = 0;
    int   errors = 0;

    xm_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .X_valid      (X_valid),
        .X_opc        (X_opc),
        .X_result_ALU (X_result_ALU),
        .X_st_data    (X_st_data),
        .X_dst_ptr    (X_dst_ptr),
        .X_flush      (X_flush),
        .M_stall      (M_stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .W_we         (W_we),
        .W_ptr        (W_ptr),
        .W_data       (W_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one instruction and hold it until the stage accepts it (bounded wait).
    task automatic issue(input logic [3:0] opc, input logic [7:0] res, input logic [7:0] st,
                         input logic [3:0] dst);
        int n;
        X_valid      = 1'b1;
        X_opc        = opc;
        X_result_ALU = res;
        X_st_data    = st;
        X_dst_ptr    = dst;
        n = 0;
        @(negedge clk);
        while (M_stall && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (M_stall) check("issue_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        X_valid = 1'b0;
    endtask

    task automatic push_wb(input logic [3:0] ptr, input logic [7:0] data);
        wb_t e;
        e.ptr  = ptr;
        e.data = data;
        wq.push_back(e);
    endtask

    task automatic push_mem(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                            input int delay, input logic [7:0] rdata);
        mem_t e;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.delay = delay;
        e.rdata = rdata;
        mq.push_back(e);
    endtask

    // Writeback monitor: every W_we pulse must match the oldest expected writeback.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (rst_n && W_we) begin
                if (wq.size() == 0) begin
                    check("unexpected_W_we", 32'd1, 32'd0);
                end else begin
                    e = wq.pop_front();
                    check("W_ptr", {28'd0, W_ptr}, {28'd0, e.ptr});
                    check("W_data", {24'd0, W_data}, {24'd0, e.data});
                end
            end
        end
    end

    // Memory responder: checks request fields each cycle, acks after the expected delay.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                resp_ack = 1'b0;
                cnt = 0;
                mq.delete();
                continue;
            end
            if (resp_ack) begin
                resp_ack = 1'b0;
                cnt = 0;
                if (mq.size() > 0) void'(mq.pop_front());
            end
            if (mem_req) begin
                if (mq.size() == 0) begin
                    check("unexpected_mem_req", 32'd1, 32'd0);
                end else begin
                    cnt++;
                    check("mem_we", {31'd0, mem_we}, {31'd0, mq[0].we});
                    check("mem_addr", {24'd0, mem_addr}, {24'd0, mq[0].addr});
                    check("mem_wdata", {24'd0, mem_wdata}, {24'd0, mq[0].wdata});
                    if (cnt == mq[0].delay) begin
                        resp_ack  = 1'b1;
                        mem_rdata = mq[0].rdata;
                    end
                end
            end
        end
    end

    initial begin
        // Reset state.
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_W_we", {31'd0, W_we}, 32'd0);
        check("rst_M_stall", {31'd0, M_stall}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_W_ptr", {28'd0, W_ptr}, 32'd0);
        check("rst_W_data", {24'd0, W_data}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD: single-cycle writeback pulse.
        push_wb(4'd3, 8'h2A);
        issue(OPC_ADD, 8'h2A, 8'h00, 4'd3);
        @(negedge clk);
        check("add_W_we", {31'd0, W_we}, 32'd1);
        @(negedge clk);
        check("add_W_we_drop", {31'd0, W_we}, 32'd0);
        @(posedge clk);
        #1;

        // LD with ack on the third request cycle.
        push_mem(1'b0, 8'h10, 8'h00, 3, 8'h77);
        push_wb(4'd5, 8'h77);
        issue(OPC_LD, 8'h10, 8'hEE, 4'd5);
        @(negedge clk);
        check("ld_stall_c1", {31'd0, M_stall}, 32'd1);
        @(negedge clk);
        check("ld_stall_c2", {31'd0, M_stall}, 32'd1);
        @(negedge clk);
        check("ld_stall_c3", {31'd0, M_stall}, 32'd0);
        check("ld_req_c3", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        check("ld_req_drop", {31'd0, mem_req}, 32'd0);
        check("ld_W_we", {31'd0, W_we}, 32'd1);
        @(posedge clk);
        #1;

        // ST with single-cycle ack; no writeback expected.
        push_mem(1'b1, 8'h20, 8'h55, 1, 8'hC3);
        issue(OPC_ST, 8'h20, 8'h55, 4'd8);
        repeat (3) @(negedge clk);
        check("st_req_done", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1;

        // LD acked immediately, then XOR and SUB back to back: three consecutive writebacks.
        push_mem(1'b0, 8'h30, 8'h00, 1, 8'hA5);
        push_wb(4'd2, 8'hA5);
        push_wb(4'd1, 8'h0F);
        push_wb(4'd7, 8'h3C);
        issue(OPC_LD, 8'h30, 8'h00, 4'd2);
        issue(OPC_XOR, 8'h0F, 8'h00, 4'd1);
        issue(OPC_SUB, 8'h3C, 8'h00, 4'd7);
        @(negedge clk);
        check("b2b_W_we_xor", {31'd0, W_we}, 32'd1);
        @(negedge clk);
        check("b2b_W_we_sub", {31'd0, W_we}, 32'd1);
        @(negedge clk);
        check("b2b_W_we_end", {31'd0, W_we}, 32'd0);
        @(posedge clk);
        #1;

        // LD then ST back to back: mem_req stays high across the handoff.
        push_mem(1'b0, 8'h40, 8'h00, 1, 8'h3C);
        push_mem(1'b1, 8'h41, 8'h99, 2, 8'h00);
        push_wb(4'd4, 8'h3C);
        issue(OPC_LD, 8'h40, 8'h00, 4'd4);
        issue(OPC_ST, 8'h41, 8'h99, 4'd0);
        @(negedge clk);
        check("ldst_req_held", {31'd0, mem_req}, 32'd1);
        repeat (3) @(negedge clk);
        check("ldst_req_done", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1;

        // Flushed ADD and a NOP: neither writes back. SET_CONST does.
        X_flush = 1'b1;
        X_valid = 1'b1;
        X_opc = OPC_ADD;
        X_result_ALU = 8'h66;
        X_dst_ptr = 4'd6;
        @(posedge clk);
        #1;
        X_flush = 1'b0;
        X_valid = 1'b0;
        @(negedge clk);
        check("flush_W_we", {31'd0, W_we}, 32'd0);
        @(posedge clk);
        #1;
        issue(OPC_NOP, 8'h12, 8'h00, 4'd2);
        push_wb(4'hF, 8'hFF);
        issue(OPC_SET_CONST, 8'hFF, 8'h00, 4'hF);

        // Stray ack while idle is ignored.
        repeat (2) @(posedge clk);
        #1;
        idle_ack = 1'b1;
        @(negedge clk);
        check("idle_ack_stall", {31'd0, M_stall}, 32'd0);
        @(posedge clk);
        #1;
        idle_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_req", {31'd0, mem_req}, 32'd0);
        check("idle_ack_W_we", {31'd0, W_we}, 32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a load: outputs drop at once, writeback is lost.
        push_mem(1'b0, 8'h80, 8'h00, 50, 8'h11);
        issue(OPC_LD, 8'h80, 8'h00, 4'd6);
        repeat (2) @(negedge clk);
        check("midrst_req_before", {31'd0, mem_req}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        check("midrst_W_we", {31'd0, W_we}, 32'd0);
        check("midrst_M_stall", {31'd0, M_stall}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_req", {31'd0, mem_req}, 32'd0);
        check("postrst_stall", {31'd0, M_stall}, 32'd0);
        push_wb(4'd9, 8'h11);
        issue(OPC_ADD, 8'h11, 8'h00, 4'd9);

        repeat (5) @(negedge clk);
        check("wb_queue_empty", wq.size(), 32'd0);
        check("mem_queue_empty", mq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/xm_stage.md
Name: xm_stage

Overview:
- Execute-to-memory/writeback stage. Sits directly downstream of the core ALU and consumes its result, opcode and destination pointer.
- ALU ops: registers the result and issues a register-file write one cycle later.
- LD/ST: uses the ALU result as the address and runs a req/ack handshake with core-local memory. Back-pressures the decode/execute stage until the access completes.

Parameters:
- REG_SIZE, 8, data/register width (matches shared REG_SIZE)
- ADDR_SIZE, 8, memory address width; address = X_result_ALU[ADDR_SIZE-1:0]
- REG_PTR_SIZE, 4, register pointer width
- OPC_SIZE, 4, opcode width (matches shared INSN_OPC_RANGE)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- X_valid  in  1  execute stage presents an instruction this cycle
- X_opc  in  OPC_SIZE  opcode of the executed instruction
- X_result_ALU  in  REG_SIZE  ALU result; memory address for LD/ST
- X_st_data  in  REG_SIZE  store data (src_1 value)
- X_dst_ptr  in  REG_PTR_SIZE  destination register
- X_flush  in  1  squash the instruction presented this cycle
- M_stall  out  1  upstream must hold X_* stable while high
- mem_req  out  1  memory request
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  ADDR_SIZE  memory address
- mem_wdata  out  REG_SIZE  store data
- mem_ack  in  1  access complete; mem_rdata valid in the same cycle
- mem_rdata  in  REG_SIZE  load data
- W_we  out  1  register-file write enable
- W_ptr  out  REG_PTR_SIZE  write pointer
- W_data  out  REG_SIZE  write data

Behaviour:
- Reset (async, rst_n=0): state IDLE. mem_req, mem_we, W_we = 0. mem_addr, mem_wdata, W_ptr, W_data = 0. M_stall = 0.
- Accept: at a clock edge, an instruction is accepted when X_valid=1, X_flush=0 and M_stall=0.
- Writing opcodes: ADD, SUB, MUL, DIV, CMPGE, RSHIFT, LSHIFT, AND, OR, XOR, SET_CONST, LD. All other opcodes (ST, NOP, control) never assert W_we.
- State IDLE:
  - Accepted non-memory writing op: next cycle W_we=1, W_ptr=X_dst_ptr, W_data=X_result_ALU. Latency 1. State stays IDLE.
  - Accepted non-memory, non-writing op: no visible effect.
  - Accepted LD/ST: register mem_addr, mem_wdata (ST only, else 0), mem_we; set mem_req=1; go to MEM. For LD, hold X_dst_ptr internally.
- State MEM:
  - mem_req held high; mem_addr/mem_we/mem_wdata held stable.
  - M_stall = (state==MEM) & ~mem_ack (combinational).
  - On an edge with mem_ack=1: mem_req drops to 0 next cycle; state returns to IDLE.
  - LD: next cycle W_we=1, W_ptr=saved ptr, W_data=mem_rdata sampled at the ack edge.
  - ST: no writeback.
  - The same ack edge may accept the next X instruction, since M_stall=0 in that cycle. Back-to-back memory ops therefore re-enter MEM with mem_req staying high; every ack retires exactly one access.
- mem_ack is ignored while mem_req=0. Minimum access: capture edge E0, req high in cycle 1, ack in cycle 1 → W_we in cycle 2.
- W_we is a single-cycle pulse per writing instruction, deasserted unless a new writeback is produced. W_ptr/W_data hold their last value when W_we=0.
- X_flush: squashes only the instruction presented that cycle. An in-flight memory access is never cancelled.
- X_valid=0 or flushed while IDLE: no state change, W_we=0 next cycle.
- Reset mid-access: mem_req drops immediately (async). A pending LD writeback is lost.
- Widths: address is a truncation of X_result_ALU to ADDR_SIZE. No sign extension anywhere.

Decomposition:
- Shared package/define file: opcode constants (ADD..XOR, SET_CONST, LD, ST, NOP), REG_SIZE, REG_PTR_SIZE, ADDR_SIZE, state encoding (IDLE=0, MEM=1), and a writes_reg(opc) function/macro shared with the hazard logic.
- Optional sub-module xm_wb_reg: W_we/W_ptr/W_data output register with source select (ALU vs mem_rdata).
- FSM and handshake remain in xm_stage.

Test Plan:
- Reset mid-stream: rst_n low during MEM with req high → mem_req, W_we, M_stall = 0 immediately; IDLE after release.
- ADD: result 0x2A, dst 3, X_valid=1 → next cycle W_we=1, W_ptr=3, W_data=0x2A; following cycle W_we=0.
- LD: result 0x10, dst 5, memory acks after 3 cycles with rdata 0x77 → mem_req=1, mem_we=0, mem_addr=0x10 for 3 cycles; M_stall=1 in the first 2; W_we=1, W_ptr=5, W_data=0x77 the cycle after ack.
- ST: addr 0x20, st_data 0x55, 1-cycle ack → mem_we=1, mem_wdata=0x55; W_we never asserted.
- Back-to-back: LD (ack in first cycle) followed by XOR result 0x0F, dst 1 → ack edge accepts XOR; W_we high on two consecutive cycles (LD data, then 0x0F).
- Flush/ignore: X_flush=1 with ADD → no W_we; mem_ack=1 while idle → no state change, no writeback.
